// File: rtl/gate_sweep_controller.sv
// Exhaustive input sweep for a combinational gate under test: every input vector is held
// for DWELL cycles, the gate output is sampled at the end of the dwell and checked against EXPECT.
module gate_sweep_controller #(
    parameter int                   N_IN   = 2,
    parameter int                   DWELL  = 250,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   gate_out,
    output logic [N_IN-1:0]        gate_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [(1<<N_IN)-1:0]   fail_vec
);
    localparam int NVEC  = 1 << N_IN;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = '1;
    localparam logic [N_IN:0]    ERR_MAX  = {1'b1, {N_IN{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   gate_in_q, gate_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic [NVEC-1:0]   fail_vec_q, fail_vec_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_vec_d  = fail_vec_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_APPLY;
                    idx_d       = '0;
                    cnt_d       = '0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    fail_vec_d  = '0;
                end
            end
            S_APPLY: begin
                // Abort takes priority over the end-of-dwell sample; partial results are kept.
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (gate_out != EXPECT[idx_q]) begin
                        fail_vec_d[idx_q] = 1'b1;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                        pass_d  = (err_count_d == '0);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        busy_d    = (state_d == S_APPLY);
        done_d    = (state_d == S_DONE);
        gate_in_d = busy_d ? idx_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            gate_in_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            fail_vec_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            gate_in_q   <= gate_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign gate_in   = gate_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;

endmodule
